// File: rtl/mips_pkg.sv
// Shared MIPS32 fetch-path definitions: FSM states, fault causes and text-segment bounds.
package mips_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned CAUSE_W = 2;

  localparam logic [PC_W-1:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [PC_W-1:0] TEXT_END  = 32'h0040_1000;
  localparam logic [PC_W-1:0] RESET_PC  = TEXT_BASE;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE  = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_RANGE = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_ALIGN = 2'd2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage : mips_pkg

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (stall > jump > branch > +4) with redirect-target alignment check.
// Alignment faulting is compiled in with PC_ALIGN_CHECK_EN; otherwise targets are word-forced.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] vpc_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_taken_i,
  input  logic [PC_W-1:0] jmp_target_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic [PC_W-1:0] target_o,
  output logic            align_err_o
);

  logic            redirect;
  logic [PC_W-1:0] raw_target;

  always_comb begin
    redirect   = jmp_taken_i | br_taken_i;
    raw_target = jmp_taken_i ? jmp_target_i : br_target_i;
`ifdef PC_ALIGN_CHECK_EN
    target_o    = raw_target;
    align_err_o = ~stall_i & redirect & (raw_target[1:0] != 2'b00);
`else
    target_o    = raw_target & ~PC_W'(32'h3);
    align_err_o = 1'b0;
`endif
    if (stall_i) begin
      next_pc_o = vpc_i;
    end else if (redirect) begin
      next_pc_o = target_o;
    end else begin
      next_pc_o = vpc_i + PC_W'(4);
    end
  end

endmodule : pc_next_sel

// File: rtl/pc_fetch_unit.sv
// MIPS32 program-counter stage: BOOT/RUN/FAULT control, PC register and sticky fetch-fault capture.
// Optional redirect alignment faulting is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               jmp_taken,
  input  logic [PC_W-1:0]    jmp_target,
  input  logic               invpc,
  input  logic               clear_fault,
  output logic [PC_W-1:0]    vpc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               fetch_valid,
  output logic               fault,
  output logic [PC_W-1:0]    fault_pc,
  output logic [CAUSE_W-1:0] fault_cause
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      vpc_q, vpc_d;
  logic                 fault_q, fault_d;
  logic [PC_W-1:0]      fault_pc_q, fault_pc_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;

  logic [PC_W-1:0]      next_pc;
  logic [PC_W-1:0]      redir_target;
  logic                 align_err;

  pc_next_sel u_next_sel (
    .vpc_i        (vpc_q),
    .stall_i      (stall),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .jmp_taken_i  (jmp_taken),
    .jmp_target_i (jmp_target),
    .next_pc_o    (next_pc),
    .target_o     (redir_target),
    .align_err_o  (align_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      vpc_q      <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      vpc_q      <= vpc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      cause_q    <= cause_d;
    end
  end

  // Range faults win over alignment faults and over any redirect or stall.
  always_comb begin
    state_d    = state_q;
    vpc_d      = vpc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    cause_d    = cause_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        vpc_d   = RESET_PC;
      end
      RUN: begin
        if (invpc) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = vpc_q;
          cause_d    = CAUSE_RANGE;
        end else if (align_err) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = redir_target;
          cause_d    = CAUSE_ALIGN;
        end else begin
          vpc_d = next_pc;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d    = BOOT;
          vpc_d      = RESET_PC;
          fault_d    = 1'b0;
          fault_pc_d = '0;
          cause_d    = CAUSE_NONE;
        end
      end
      default: begin
        state_d = BOOT;
        vpc_d   = RESET_PC;
      end
    endcase
  end

  assign vpc         = vpc_q;
  assign pc_plus4    = vpc_q + PC_W'(4);
  assign fetch_valid = (state_q == RUN) & ~invpc;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fault_cause = cause_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural text-segment decoder driving invpc.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_taken;
  logic [31:0] jmp_target;
  logic        invpc;
  logic        clear_fault;
  logic [31:0] vpc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  fault_cause;

  int vectors;
  int miscompares;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_taken   (jmp_taken),
    .jmp_target  (jmp_target),
    .invpc       (invpc),
    .clear_fault (clear_fault),
    .vpc         (vpc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory covers [0x0040_0000, 0x0040_1000).
  assign invpc = (vpc < 32'h0040_0000) || (vpc >= 32'h0040_1000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_vpc, input logic e_fv,
                           input logic e_fault, input logic [31:0] e_fpc, input logic [1:0] e_cause);
    chk({tag, ".vpc"},         vpc,                  e_vpc);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid),     32'(e_fv));
    chk({tag, ".fault"},       32'(fault),           32'(e_fault));
    chk({tag, ".fault_pc"},    fault_pc,             e_fpc);
    chk({tag, ".fault_cause"}, 32'(fault_cause),     32'(e_cause));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    jmp_taken   = 1'b0;
    jmp_target  = 32'h0;
    clear_fault = 1'b0;

    #12;
    chk_state("reset", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 2'd0);
    chk("reset.pc_plus4", pc_plus4, 32'h0040_0004);
    rst_n = 1'b1;
    #1;
    chk_state("boot", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 2'd0);

    step();
    chk_state("run0", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 2'd0);
    step();
    chk_state("run1", 32'h0040_0004, 1'b1, 1'b0, 32'h0, 2'd0);
    step();
    chk_state("run2", 32'h0040_0008, 1'b1, 1'b0, 32'h0, 2'd0);

    // Jump beats branch in the same cycle.
    jmp_taken = 1'b1; jmp_target = 32'h0040_0100;
    br_taken  = 1'b1; br_target  = 32'h0040_0200;
    step();
    jmp_taken = 1'b0; br_taken = 1'b0;
    chk("jmp_pri.vpc", vpc, 32'h0040_0100);
    chk("jmp_pri.pc_plus4", pc_plus4, 32'h0040_0104);
    step();
    chk("br_off.vpc", vpc, 32'h0040_0104);

    br_taken = 1'b1; br_target = 32'h0040_0010;
    step();
    br_taken = 1'b0;
    chk("br.vpc", vpc, 32'h0040_0010);

    // Stall holds for three cycles even with a branch pending.
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.vpc", i), vpc, 32'h0040_0010);
    end
    stall = 1'b0; br_taken = 1'b0;
    step();
    chk_state("post_stall", 32'h0040_0014, 1'b1, 1'b0, 32'h0, 2'd0);

    // Misaligned redirect target.
    jmp_taken = 1'b1; jmp_target = 32'h0040_0102;
    step();
    jmp_taken = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk_state("align", 32'h0040_0014, 1'b0, 1'b1, 32'h0040_0102, 2'd2);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk_state("align_clr_boot", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 2'd0);
    step();
    chk_state("align_clr_run", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 2'd0);
`else
    chk_state("align", 32'h0040_0100, 1'b1, 1'b0, 32'h0, 2'd0);
`endif

    // Out-of-range jump: decoder flags it, fault follows next cycle.
    jmp_taken = 1'b1; jmp_target = 32'h0040_1000;
    step();
    jmp_taken = 1'b0;
    chk_state("oor_pre", 32'h0040_1000, 1'b0, 1'b0, 32'h0, 2'd0);
    step();
    chk_state("oor_fault", 32'h0040_1000, 1'b0, 1'b1, 32'h0040_1000, 2'd1);

    // Redirects and stall are ignored while faulted.
    jmp_taken = 1'b1; jmp_target = 32'h0040_0300; stall = 1'b1;
    step();
    jmp_taken = 1'b0; stall = 1'b0;
    chk_state("fault_frozen", 32'h0040_1000, 1'b0, 1'b1, 32'h0040_1000, 2'd1);

    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk_state("clr_boot", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 2'd0);
    step();
    chk_state("clr_run", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 2'd0);
    step();
    chk("clr_run1.vpc", vpc, 32'h0040_0004);

    // clear_fault in RUN has no effect.
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk_state("clr_in_run", 32'h0040_0008, 1'b1, 1'b0, 32'h0, 2'd0);

    // Re-enter FAULT, then assert reset between clock edges.
    jmp_taken = 1'b1; jmp_target = 32'h0040_2000;
    step();
    jmp_taken = 1'b0;
    step();
    chk_state("fault2", 32'h0040_2000, 1'b0, 1'b1, 32'h0040_2000, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 2'd0);
    chk("async_rst.pc_plus4", pc_plus4, 32'h0040_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_fetch_unit
